// File: rtl/wb_regfile.sv
// Writeback pipeline register plus multi-port register file: one WB entry, up to two commits per op.
// Optional macro WB_BYPASS_EN forwards pending (uncommitted) results onto the read ports.
module wb_regfile #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned HI_REG = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic [2:0]       alu_sel,
  input  logic [3:0]       rd1,
  input  logic [3:0]       rd2,
  input  logic [WIDTH-1:0] op1data,
  input  logic [WIDTH-1:0] op2data,
  input  logic [WIDTH-1:0] r15data,
  input  logic [3:0]       ra_addr,
  input  logic [3:0]       rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             wb_busy
);

  localparam int unsigned AW = 4;

  typedef enum logic [2:0] {
    SEL_MULHI  = 3'b010,
    SEL_DIVREM = 3'b011,
    SEL_SWAP   = 3'b101
  } alu_sel_e;

  // Pending writeback entry
  logic             pend_valid_q, pend_valid_d;
  logic [2:0]       pend_sel_q,   pend_sel_d;
  logic [AW-1:0]    pend_rd1_q,   pend_rd1_d;
  logic [AW-1:0]    pend_rd2_q,   pend_rd2_d;
  logic [WIDTH-1:0] pend_op1_q,   pend_op1_d;
  logic [WIDTH-1:0] pend_op2_q,   pend_op2_d;
  logic [WIDTH-1:0] pend_hi_q,    pend_hi_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             capture;
  logic             commit;
  logic             w2_en;
  logic [AW-1:0]    w2_idx;
  logic [WIDTH-1:0] w2_data;

  assign in_ready = ~pend_valid_q | ~stall;
  assign wb_busy  = pend_valid_q;
  assign capture  = in_valid & in_ready;
  assign commit   = pend_valid_q & ~stall;

  // Second write port target is decided by the producing op's select
  always_comb begin
    w2_en   = 1'b0;
    w2_idx  = '0;
    w2_data = '0;
    case (pend_sel_q)
      SEL_SWAP: begin
        w2_en   = 1'b1;
        w2_idx  = pend_rd2_q;
        w2_data = pend_op2_q;
      end
      SEL_MULHI, SEL_DIVREM: begin
        w2_en   = 1'b1;
        w2_idx  = AW'(HI_REG);
        w2_data = pend_hi_q;
      end
      default: begin
        w2_en   = 1'b0;
        w2_idx  = '0;
        w2_data = '0;
      end
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    pend_rd1_d   = pend_rd1_q;
    pend_rd2_d   = pend_rd2_q;
    pend_op1_d   = pend_op1_q;
    pend_op2_d   = pend_op2_q;
    pend_hi_d    = pend_hi_q;
    if (capture) begin
      pend_valid_d = 1'b1;
      pend_sel_d   = alu_sel;
      pend_rd1_d   = rd1;
      pend_rd2_d   = rd2;
      pend_op1_d   = op1data;
      pend_op2_d   = op2data;
      pend_hi_d    = r15data;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  // W1 is applied last so it overrides W2 when both target the same register
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit) begin
        if (w2_en && (w2_idx == AW'(i)))
          regs_d[i] = w2_data;
        if (pend_rd1_q == AW'(i))
          regs_d[i] = pend_op1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_rd1_q   <= '0;
      pend_rd2_q   <= '0;
      pend_op1_q   <= '0;
      pend_op2_q   <= '0;
      pend_hi_q    <= '0;
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_rd1_q   <= pend_rd1_d;
      pend_rd2_q   <= pend_rd2_d;
      pend_op1_q   <= pend_op1_d;
      pend_op2_q   <= pend_op2_d;
      pend_hi_q    <= pend_hi_d;
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  // Addresses with no matching register fall through to zero
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (ra_addr == AW'(i))
        ra_data = regs_q[i];
      if (rb_addr == AW'(i))
        rb_data = regs_q[i];
    end
`ifdef WB_BYPASS_EN
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (pend_valid_q && (ra_addr == AW'(i))) begin
        if (pend_rd1_q == ra_addr)
          ra_data = pend_op1_q;
        else if (w2_en && (w2_idx == ra_addr))
          ra_data = w2_data;
      end
      if (pend_valid_q && (rb_addr == AW'(i))) begin
        if (pend_rd1_q == rb_addr)
          rb_data = pend_op1_q;
        else if (w2_en && (w2_idx == rb_addr))
          rb_data = w2_data;
      end
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an operation-level register file model.
module tb_wb_regfile;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int HI = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         stall;
  logic [2:0]   alu_sel;
  logic [3:0]   rd1, rd2;
  logic [W-1:0] op1data, op2data, r15data;
  logic [3:0]   ra_addr, rb_addr;
  logic [W-1:0] ra_data, rb_data;
  logic         wb_busy;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.WIDTH(W), .NREGS(N), .HI_REG(HI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .alu_sel(alu_sel), .rd1(rd1), .rd2(rd2), .op1data(op1data), .op2data(op2data),
    .r15data(r15data), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
    .rb_data(rb_data), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: an op is a list of register writes applied when it retires
  typedef struct {
    bit           v;
    logic [2:0]   sel;
    logic [3:0]   rd1, rd2;
    logic [W-1:0] op1, op2, hi;
  } ent_t;

  logic [W-1:0] m_regs [N];
  ent_t         m_pend;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_pend.v = 0;
  endfunction

  function automatic void m_retire(input ent_t e);
    if (e.sel == 3'b101) m_regs[e.rd2] = e.op2;
    else if (e.sel == 3'b010 || e.sel == 3'b011) m_regs[HI] = e.hi;
    m_regs[e.rd1] = e.op1;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [3:0] a);
`ifdef WB_BYPASS_EN
    if (m_pend.v) begin
      if (a == m_pend.rd1) return m_pend.op1;
      if (m_pend.sel == 3'b101 && a == m_pend.rd2) return m_pend.op2;
      if ((m_pend.sel == 3'b010 || m_pend.sel == 3'b011) && a == 4'(HI)) return m_pend.hi;
    end
`endif
    return m_regs[a];
  endfunction

  // One cycle: drive at negedge, check combinational outputs, advance model at posedge
  task automatic step(input bit v, input bit st, input logic [2:0] sel,
                      input logic [3:0] r1, input logic [3:0] r2,
                      input logic [W-1:0] o1, input logic [W-1:0] o2, input logic [W-1:0] h,
                      input logic [3:0] ra, input logic [3:0] rb);
    bit ready, cmt;
    in_valid = v; stall = st; alu_sel = sel; rd1 = r1; rd2 = r2;
    op1data = o1; op2data = o2; r15data = h; ra_addr = ra; rb_addr = rb;
    #1;
    ready = !m_pend.v || !st;
    check("in_ready", in_ready, ready);
    check("wb_busy", wb_busy, m_pend.v);
    check("ra_data", ra_data, m_read(ra));
    check("rb_data", rb_data, m_read(rb));
    @(posedge clk);
    cmt = m_pend.v && !st;
    if (cmt) m_retire(m_pend);
    if (v && ready) begin
      m_pend.v = 1; m_pend.sel = sel; m_pend.rd1 = r1; m_pend.rd2 = r2;
      m_pend.op1 = o1; m_pend.op2 = o2; m_pend.hi = h;
    end else if (cmt) m_pend.v = 0;
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    step(0, st, 3'b000, 4'd0, 4'd0, '0, '0, '0, 4'd0, 4'd15);
  endtask

  task automatic peek(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    ra_addr = ra; rb_addr = rb;
    #1;
    check({tag, "_a"}, ra_data, ea);
    check({tag, "_b"}, rb_data, eb);
  endtask

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, 3'($urandom),
           4'($urandom), 4'($urandom), W'($urandom), W'($urandom), W'($urandom),
           4'($urandom), 4'($urandom));
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; stall = 0; alu_sel = '0; rd1 = '0; rd2 = '0;
    op1data = '0; op2data = '0; r15data = '0; ra_addr = '0; rb_addr = '0;
    m_reset();
    @(negedge clk);
    #1;
    check("rst_busy", wb_busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    peek("rst_rd", 4'd3, 4'd15, 16'h0, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // ADD
    step(1, 0, 3'b000, 4'd3, 4'd0, 16'h0007, 16'h1111, 16'h5555, 4'd3, 4'd15);
    idle(0);
    peek("add", 4'd3, 4'd15, 16'h0007, 16'h0000);
    // MUL writes high half into HI_REG
    step(1, 0, 3'b010, 4'd2, 4'd0, 16'h0000, 16'h2222, 16'h0001, 4'd2, 4'd15);
    idle(0);
    peek("mul", 4'd2, 4'd15, 16'h0000, 16'h0001);
    // SWAP, then SWAP into the same register
    step(1, 0, 3'b101, 4'd4, 4'd5, 16'hBBBB, 16'hAAAA, 16'h3333, 4'd4, 4'd5);
    idle(0);
    peek("swap", 4'd4, 4'd5, 16'hBBBB, 16'hAAAA);
    step(1, 0, 3'b101, 4'd6, 4'd6, 16'hBBBB, 16'hAAAA, 16'h3333, 4'd6, 4'd6);
    idle(0);
    peek("swap_col", 4'd6, 4'd6, 16'hBBBB, 16'hBBBB);
    // DIV targeting HI_REG as primary destination: op1 wins
    step(1, 0, 3'b011, 4'd15, 4'd0, 16'h00F0, 16'h0000, 16'h0F00, 4'd15, 4'd2);
    idle(0);
    peek("div_col", 4'd15, 4'd2, 16'h00F0, 16'h0000);

    // Pending result visibility before commit
    step(1, 1, 3'b000, 4'd7, 4'd0, 16'h1234, 16'h0000, 16'h0000, 4'd7, 4'd3);
`ifdef WB_BYPASS_EN
    peek("byp_pend", 4'd7, 4'd3, 16'h1234, 16'h0007);
`else
    peek("byp_pend", 4'd7, 4'd3, 16'h0000, 16'h0007);
`endif
    idle(0);
    peek("byp_done", 4'd7, 4'd3, 16'h1234, 16'h0007);

    // Stall holds the entry; release commits old and captures new on one edge
    step(1, 0, 3'b000, 4'd8, 4'd0, 16'h0808, 16'h0000, 16'h0000, 4'd8, 4'd9);
    for (int k = 0; k < 3; k++)
      step(1, 1, 3'b000, 4'd9, 4'd0, 16'h0909, 16'h0000, 16'h0000, 4'd8, 4'd9);
    check("stall_ready", in_ready, 1'b0);
`ifdef WB_BYPASS_EN
    peek("stall_hold", 4'd8, 4'd9, 16'h0808, 16'h0000);
`else
    peek("stall_hold", 4'd8, 4'd9, 16'h0000, 16'h0000);
`endif
    step(1, 0, 3'b000, 4'd9, 4'd0, 16'h0909, 16'h0000, 16'h0000, 4'd8, 4'd9);
    check("stall_busy", wb_busy, 1'b1);
`ifdef WB_BYPASS_EN
    peek("stall_rel", 4'd8, 4'd9, 16'h0808, 16'h0909);
`else
    peek("stall_rel", 4'd8, 4'd9, 16'h0808, 16'h0000);
`endif
    idle(0);
    peek("stall_fin", 4'd9, 4'd8, 16'h0909, 16'h0808);

    rand_steps(300);

    // Reset mid-operation discards the pending entry
    step(1, 1, 3'b101, 4'd10, 4'd11, 16'hDEAD, 16'hBEEF, 16'hCAFE, 4'd10, 4'd11);
    in_valid = 1; stall = 0; rd1 = 4'd12; op1data = 16'h5A5A;
    #1 rst = 1'b1;
    m_reset();
    #1;
    check("mrst_busy", wb_busy, 1'b0);
    check("mrst_ready", in_ready, 1'b1);
    for (int a = 0; a < N; a += 2)
      peek("mrst_rd", 4'(a), 4'(a + 1), 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(0);
    check("mrst_busy2", wb_busy, 1'b0);
    peek("mrst_nocommit", 4'd10, 4'd11, 16'h0, 16'h0);
    peek("mrst_nocommit2", 4'd12, 4'd15, 16'h0, 16'h0);

    rand_steps(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage and register file sitting directly downstream of the execute ALU. It latches the three ALU result buses (op1data, op2data, r15) with destination and opcode into a WB pipeline register, then commits them on the next edge. It commits up to two writes per operation: primary result, swap partner, or high/remainder into R15. It also supplies two combinational read ports that feed the ALU a/b operands.

Parameters:
WIDTH, 16, data width of registers and result buses
NREGS, 16, number of architectural registers (index width = clog2(NREGS))
HI_REG, 15, register receiving the high product / remainder

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  ALU result present this cycle
in_ready  out  1  stage can accept a result this cycle
stall  in  1  hold the pending WB entry (no commit)
alu_sel  in  3  ALU select of the producing op (000..111)
rd1  in  4  destination for op1data
rd2  in  4  destination for op2data (used only when alu_sel==101)
op1data  in  WIDTH  ALU primary result
op2data  in  WIDTH  ALU secondary result (swap)
r15data  in  WIDTH  ALU high product / remainder
ra_addr  in  4  read port A address
rb_addr  in  4  read port B address
ra_data  out  WIDTH  read port A data
rb_data  out  WIDTH  read port B data
wb_busy  out  1  pending WB entry valid

Behaviour:
- Reset (async, rst=1): all NREGS registers = 0; pending entry cleared; wb_busy=0; in_ready=1. Reset mid-operation discards the pending entry with no commit.
- Pending entry: pend_valid, pend_sel, pend_rd1, pend_rd2, pend_op1, pend_op2, pend_hi.
- in_ready = ~pend_valid | ~stall (combinational).
- Capture: in_valid & in_ready at edge -> pending entry loaded from inputs; pend_valid=1.
- Commit: at any edge with pend_valid & ~stall, write back the pending entry:
  - port W1: regs[pend_rd1] <= pend_op1, always.
  - port W2: pend_sel==101 -> regs[pend_rd2] <= pend_op2; pend_sel==010 or 011 -> regs[HI_REG] <= pend_hi; otherwise no W2 write.
  - collision (W1 and W2 same index): W1 (op1) wins.
- Commit and capture on same edge are allowed: old entry commits, new entry loads; throughput 1 op/cycle.
- No capture and commit -> pend_valid=0 after edge. Stall with pend_valid=1 -> entry held unchanged, registers unchanged.
- Latency: result presented at cycle N is architecturally visible in regs after edge N+1 (visible on read ports from cycle N+2 without bypass).
- Reads: ra_data=regs[ra_addr], rb_data=regs[rb_addr], combinational; out-of-range addresses (>=NREGS) read 0.
- wb_busy = pend_valid.
- alu_sel values outside defined set cannot occur (3 bits fully decoded); 000,001,100,110,111 write W1 only.

Optional Feature:
WB_BYPASS_EN: when defined, read ports forward pending, not-yet-committed data: if pend_valid and address matches a pending write target, return the pending value (W1 wins on collision, same as commit), regardless of stall. When undefined, read ports return committed register contents only.

Test Plan:
- Reset: assert rst mid-run with pend_valid=1 -> all regs read 0, wb_busy=0, in_ready=1, no commit after release.
- ADD: alu_sel=000, rd1=3, op1data=0x0007 -> regs[3]=0x0007 two cycles later, regs[15] unchanged.
- MUL: alu_sel=010, rd1=2, op1data=0x0000, r15data=0x0001 -> regs[2]=0x0000, regs[15]=0x0001 after same edge.
- SWAP: alu_sel=101, rd1=4, rd2=5, op1data=0xBBBB, op2data=0xAAAA -> regs[4]=0xBBBB, regs[5]=0xAAAA; repeat with rd1=rd2=6 -> regs[6]=0xBBBB.
- Stall: pending entry, stall=1 for 3 cycles with in_valid=1 -> in_ready=0, no writes, regs unchanged; stall drops -> commit and new capture on same edge.
- Bypass (WB_BYPASS_EN): pending rd1=7, op1data=0x1234, ra_addr=7 -> ra_data=0x1234 before commit; without macro ra_data shows old value until commit.
